// File: rtl/adt7310_pkg.sv
// Shared definitions for the ADT7310 SPI responder model.
// Holds the register address map, the fixed ID value, the conversion
// mode encodings of config[6:5] and the responder FSM state type.
package adt7310_pkg;

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CONFIG = 3'd1;
  localparam logic [2:0] ADDR_TEMP   = 3'd2;
  localparam logic [2:0] ADDR_ID     = 3'd3;

  localparam logic [7:0] ID_VALUE = 8'hC3;

  localparam logic [1:0] MODE_CONT     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_1SPS     = 2'b10;
  localparam logic [1:0] MODE_SHUTDOWN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD,
    ST_WR
  } state_t;

  // Index of the last data bit of a read/write transfer: the temperature
  // register is 16 bits wide, everything else is 8 bits.
  function automatic logic [3:0] last_bit_idx(input logic [2:0] addr);
    return (addr == ADDR_TEMP) ? 4'd15 : 4'd7;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, followed by an edge
// register that produces single-cycle rise/fall pulses.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous pin input
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized 0->1 / 1->0 transitions
// All stages reset to 1, matching the idle level of SCLK (mode 3) and CS_n.
module spi_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/adt7310_spi_responder.sv
// SPI mode-3 responder modelling the ADT7310 register interface.
// Decodes command bytes, serves register reads from a snapshot shift
// register, accepts config writes and runs the conversion timer that
// latches Temperature_i into the temperature register.
// Ports:
//   Reset_n_i, Clk_i       : async active-low reset, sole clock
//   SCLK_i, CS_n_i, MOSI_i : asynchronous SPI pins (sampled, never clocks)
//   MISO_o                 : responder data out, 1 while deselected
//   Temperature_i          : value latched at end of each conversion
//   ConvCyclesPreset_i     : Clk_i cycles per conversion (minus one)
//   ConfigReg_o            : configuration register
//   Busy_o                 : conversion counter running
module adt7310_spi_responder
  import adt7310_pkg::*;
(
  input  logic        Reset_n_i,
  input  logic        Clk_i,
  input  logic        SCLK_i,
  input  logic        CS_n_i,
  input  logic        MOSI_i,
  output logic        MISO_o,
  input  logic [15:0] Temperature_i,
  input  logic [15:0] ConvCyclesPreset_i,
  output logic [7:0]  ConfigReg_o,
  output logic        Busy_o
);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync u_sclk_sync (.clk(Clk_i), .rst_n(Reset_n_i), .din(SCLK_i),
                             .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_sync u_cs_sync   (.clk(Clk_i), .rst_n(Reset_n_i), .din(CS_n_i),
                             .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall));
  spi_edge_sync u_mosi_sync (.clk(Clk_i), .rst_n(Reset_n_i), .din(MOSI_i),
                             .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  state_t      state_q, state_d;
  logic [6:0]  shift_q;
  logic [3:0]  bit_cnt_q;
  logic [2:0]  addr_q;
  logic        cont_q;
  logic [15:0] rd_shift_q;
  logic        miso_q;
  logic [7:0]  cfg_q;
  logic [15:0] temp_q;
  logic        rdy_n_q;
  logic [15:0] conv_cnt_q;
  logic        busy_q;

  logic [7:0]  in_byte;
  logic        bit_last;
  logic        cmd_done, rd_word_done, wr_done, wr_commit, temp_rd_done;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;

  // Byte completed by the bit arriving this cycle.
  assign in_byte  = {shift_q, mosi_level};
  assign bit_last = (bit_cnt_q == last_bit_idx(addr_q));

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cmd_done     = 1'b0;
    rd_word_done = 1'b0;
    wr_done      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (sclk_rise && bit_cnt_q == 4'd7) begin
          cmd_done = 1'b1;
          if (!in_byte[7]) state_d = in_byte[6] ? ST_RD : ST_WR;
        end
      end
      ST_RD: begin
        if (sclk_rise && bit_last) begin
          rd_word_done = 1'b1;
          if (!cont_q) state_d = ST_CMD;
        end
      end
      ST_WR: begin
        if (sclk_rise && bit_last) begin
          wr_done = 1'b1;
          state_d = ST_CMD;
        end
      end
    endcase
    if (cs_rise) begin
      state_d      = ST_IDLE;
      cmd_done     = 1'b0;
      rd_word_done = 1'b0;
      wr_done      = 1'b0;
    end
  end

  assign wr_commit    = wr_done && (addr_q == ADDR_CONFIG);
  assign temp_rd_done = rd_word_done && (addr_q == ADDR_TEMP);

  // During CMD the address is still arriving, so the snapshot mux looks at
  // the incoming byte; a continuous reload reuses the stored address.
  assign rd_addr = (state_q == ST_CMD) ? in_byte[5:3] : addr_q;

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_STATUS: rd_data = {rdy_n_q, 15'd0};
      ADDR_CONFIG: rd_data = {cfg_q, 8'h00};
      ADDR_TEMP:   rd_data = temp_q;
      ADDR_ID:     rd_data = {ID_VALUE, 8'h00};
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      addr_q     <= '0;
      cont_q     <= 1'b0;
      rd_shift_q <= '0;
      miso_q     <= 1'b1;
    end else if (cs_rise || state_q == ST_IDLE) begin
      bit_cnt_q <= '0;
      miso_q    <= 1'b1;
    end else begin
      if (sclk_rise) begin
        shift_q <= in_byte[6:0];
        if (cmd_done) begin
          bit_cnt_q  <= '0;
          addr_q     <= in_byte[5:3];
          cont_q     <= in_byte[2];
          rd_shift_q <= rd_data;
        end else if (rd_word_done || wr_done) begin
          bit_cnt_q <= '0;
          if (rd_word_done && cont_q) rd_shift_q <= rd_data;
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end
      if (sclk_fall) begin
        if (state_q == ST_RD) begin
          miso_q     <= rd_shift_q[15];
          rd_shift_q <= {rd_shift_q[14:0], 1'b0};
        end else begin
          miso_q <= 1'b1;
        end
      end
    end
  end

  // A config commit restarts the timer even if a conversion completes in
  // the same cycle; a completion coinciding with the end of a temperature
  // read leaves RDY_n low because its assignment comes last.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      cfg_q      <= '0;
      temp_q     <= '0;
      rdy_n_q    <= 1'b1;
      conv_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      if (temp_rd_done) rdy_n_q <= 1'b1;
      if (wr_commit) begin
        cfg_q <= in_byte;
        if (in_byte[6:5] != MODE_SHUTDOWN) begin
          conv_cnt_q <= ConvCyclesPreset_i;
          busy_q     <= 1'b1;
        end else begin
          busy_q <= 1'b0;
        end
      end else if (busy_q) begin
        if (conv_cnt_q != '0) begin
          conv_cnt_q <= conv_cnt_q - 16'd1;
        end else begin
          temp_q  <= Temperature_i;
          rdy_n_q <= 1'b0;
          case (cfg_q[6:5])
            MODE_ONESHOT: begin
              cfg_q[6:5] <= MODE_SHUTDOWN;
              busy_q     <= 1'b0;
            end
            MODE_CONT, MODE_1SPS: conv_cnt_q <= ConvCyclesPreset_i;
            default: busy_q <= 1'b0;
          endcase
        end
      end
    end
  end

  assign MISO_o      = miso_q;
  assign ConfigReg_o = cfg_q;
  assign Busy_o      = busy_q;

endmodule

// File: tb/tb_adt7310_spi_responder.sv
module tb_adt7310_spi_responder;

  logic        Reset_n_i, Clk_i, SCLK_i, CS_n_i, MOSI_i;
  logic        MISO_o;
  logic [15:0] Temperature_i, ConvCyclesPreset_i;
  logic [7:0]  ConfigReg_o;
  logic        Busy_o;

  adt7310_spi_responder dut (
    .Reset_n_i(Reset_n_i), .Clk_i(Clk_i), .SCLK_i(SCLK_i), .CS_n_i(CS_n_i),
    .MOSI_i(MOSI_i), .MISO_o(MISO_o), .Temperature_i(Temperature_i),
    .ConvCyclesPreset_i(ConvCyclesPreset_i), .ConfigReg_o(ConfigReg_o), .Busy_o(Busy_o)
  );

  localparam int HALF  = 6;
  localparam int SETUP = 6;

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Register-map reference model.
  logic [7:0]  m_cfg;
  logic [15:0] m_temp;
  logic        m_rdy_n;

  function automatic logic [15:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0:    return {8'h00, m_rdy_n, 7'd0};
      3'd1:    return {8'h00, m_cfg};
      3'd2:    return m_temp;
      3'd3:    return 16'h00C3;
      default: return 16'h0000;
    endcase
  endfunction

  typedef struct {
    string       name;
    int          frame;
    int          start;
    int          len;
    logic [15:0] val;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      busy_q[$];   // expected Busy_o high run length; 0 = not timed
  int      frames_issued = 0;
  int      mon_frame = 0;

  task automatic expect_read(input string name, input int frame_ofs, input int start,
                             input int len, input logic [15:0] val);
    rd_exp_t e;
    e.name  = name;
    e.frame = frames_issued + 1 + frame_ofs;
    e.start = start;
    e.len   = len;
    e.val   = val;
    rd_q.push_back(e);
  endtask

  task automatic spi_frame(input int nbits, input logic [63:0] tx);
    CS_n_i = 1'b0;
    frames_issued++;
    repeat (SETUP) @(negedge Clk_i);
    for (int i = 0; i < nbits; i++) begin
      SCLK_i = 1'b0;
      MOSI_i = tx[63-i];
      repeat (HALF) @(negedge Clk_i);
      SCLK_i = 1'b1;
      repeat (HALF) @(negedge Clk_i);
    end
    CS_n_i = 1'b1;
    MOSI_i = 1'b1;
    repeat (HALF) @(negedge Clk_i);
  endtask

  task automatic do_read(input string name, input logic [2:0] a);
    logic [7:0] cmd;
    int len;
    cmd = {2'b01, a, 1'b0, 2'($urandom)};
    len = (a == 3'd2) ? 16 : 8;
    expect_read(name, 0, 8, len, m_reg(a));
    spi_frame(8 + len, {cmd, 56'h0});
    if (a == 3'd2) m_rdy_n = 1'b1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] data);
    logic [7:0] cmd;
    cmd = {2'b00, a, 1'b0, 2'($urandom)};
    if (a == 3'd2) spi_frame(24, {cmd, data, 40'h0});
    else           spi_frame(16, {cmd, data[7:0], 48'h0});
    if (a == 3'd1) m_cfg = data[7:0];
  endtask

  task automatic wait_busy_low(input string name, input int limit);
    for (int i = 0; i < limit && Busy_o; i++) @(negedge Clk_i);
    check(name, {31'd0, Busy_o}, 32'd0);
  endtask

  // SPI bus monitor: collects MISO on SCLK rising pin edges and pops the
  // expectation of the frame in progress.
  initial begin : spi_monitor
    logic sclk_prev, cs_prev;
    int bitn, accn;
    logic [15:0] acc;
    rd_exp_t e;
    sclk_prev = 1'b1; cs_prev = 1'b1; bitn = 0; accn = 0; acc = '0;
    forever begin
      @(posedge Clk_i);
      if (cs_prev && !CS_n_i) begin
        mon_frame++;
        bitn = 0; accn = 0; acc = '0;
        while (rd_q.size() > 0 && rd_q[0].frame < mon_frame) begin
          e = rd_q.pop_front();
          check({e.name, "_frame"}, e.frame, mon_frame);
        end
      end
      if (!CS_n_i && SCLK_i && !sclk_prev) begin
        if (rd_q.size() > 0 && rd_q[0].frame == mon_frame && bitn >= rd_q[0].start) begin
          acc = {acc[14:0], MISO_o};
          accn++;
          if (accn == rd_q[0].len) begin
            e = rd_q.pop_front();
            check(e.name, (e.len == 16) ? {16'h0, acc} : {24'h0, acc[7:0]}, {16'h0, e.val});
            accn = 0; acc = '0;
          end
        end
        bitn++;
      end
      sclk_prev = SCLK_i;
      cs_prev   = CS_n_i;
    end
  end

  // Busy monitor: measures each Busy_o high run in Clk_i cycles.
  initial begin : busy_monitor
    int run;
    int exp_run;
    run = 0;
    forever begin
      @(posedge Clk_i);
      if (Busy_o === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (busy_q.size() == 0) begin
          check("busy_unexpected_run", run, 0);
        end else begin
          exp_run = busy_q.pop_front();
          if (exp_run != 0) check("busy_len", run, exp_run);
        end
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [15:0] t_old, t_new;
    logic [7:0]  d;
    logic [2:0]  a;
    Reset_n_i = 1'b0; SCLK_i = 1'b1; CS_n_i = 1'b1; MOSI_i = 1'b1;
    Temperature_i = 16'h0000; ConvCyclesPreset_i = 16'd100;
    m_cfg = 8'h00; m_temp = 16'h0000; m_rdy_n = 1'b1;
    repeat (5) @(negedge Clk_i);
    check("reset_miso", {31'd0, MISO_o}, 32'd1);
    check("reset_config", {24'd0, ConfigReg_o}, 32'h00);
    check("reset_busy", {31'd0, Busy_o}, 32'd0);
    Reset_n_i = 1'b1;
    repeat (3) @(negedge Clk_i);

    expect_read("id_read", 0, 8, 8, 16'h00C3);
    spi_frame(16, {8'h58, 56'h0});
    check("miso_idle_after_id", {31'd0, MISO_o}, 32'd1);
    do_read("status_reset", 3'd0);
    do_read("temp_reset", 3'd2);

    // Command with bit7 set is ignored; the following byte is a fresh command.
    expect_read("id_after_invalid_cmd", 0, 16, 8, 16'h00C3);
    spi_frame(24, {8'h80 | 8'($urandom_range(0, 127)), 8'h58, 48'h0});

    // One-shot conversion.
    Temperature_i = 16'h0C80; ConvCyclesPreset_i = 16'd100;
    busy_q.push_back(101);
    do_write(3'd1, 16'h0020);
    wait_busy_low("oneshot_busy_timeout", 400);
    m_temp = 16'h0C80; m_rdy_n = 1'b0; m_cfg = 8'h60;
    check("config_after_oneshot", {24'd0, ConfigReg_o}, {24'd0, m_cfg});
    do_read("status_ready", 3'd0);
    do_read("temp_oneshot", 3'd2);
    do_read("status_after_temp_read", 3'd0);

    // Continuous read of three words, then CS_n raised 4 bits into the fourth.
    for (int k = 0; k < 3; k++) expect_read($sformatf("cont_read_%0d", k), 0, 8 + 16 * k, 16, m_temp);
    spi_frame(60, {8'h54, 56'h0});
    m_rdy_n = 1'b1;
    check("miso_idle_after_cont", {31'd0, MISO_o}, 32'd1);
    check("config_after_cont_abort", {24'd0, ConfigReg_o}, {24'd0, m_cfg});

    // Random config writes in shutdown mode: no conversion, readback matches.
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom) | 8'h60;
      do_write(3'd1, {8'h00, d});
      check("config_random_write", {24'd0, ConfigReg_o}, {24'd0, m_cfg});
      check("busy_shutdown_write", {31'd0, Busy_o}, 32'd0);
      do_read("config_readback", 3'd1);
    end

    // Unused addresses ignore writes and read as zero.
    for (int k = 0; k < 3; k++) begin
      a = 3'(4 + $urandom_range(0, 3));
      do_write(a, 16'($urandom));
      check("config_after_unused_write", {24'd0, ConfigReg_o}, {24'd0, m_cfg});
      do_read("unused_addr_read", a);
    end

    // 16-bit write to the temperature register is discarded; next command in frame works.
    expect_read("id_after_temp_write", 0, 32, 8, 16'h00C3);
    spi_frame(40, {8'h10, 16'($urandom), 8'h58, 8'h00, 24'h0});
    do_read("temp_after_discarded_write", 3'd2);

    // Config write aborted after 5 data bits.
    spi_frame(13, {8'h08, 8'($urandom), 48'h0});
    check("config_after_abort", {24'd0, ConfigReg_o}, {24'd0, m_cfg});

    // Conversion completes exactly as a temperature read ends: read shows the
    // snapshot, RDY_n stays low. Commit-to-read-end spacing is 300 cycles.
    t_old = m_temp;
    t_new = 16'($urandom);
    while (t_new == t_old) t_new = 16'($urandom);
    Temperature_i = t_new; ConvCyclesPreset_i = 16'd299;
    busy_q.push_back(300);
    expect_read("midread_old_temp", 1, 8, 16, t_old);
    spi_frame(16, {8'h08, 8'h20, 48'h0});
    spi_frame(24, {8'h50, 56'h0});
    wait_busy_low("midread_busy_timeout", 50);
    m_temp = t_new; m_rdy_n = 1'b0; m_cfg = 8'h60;
    check("config_after_midread", {24'd0, ConfigReg_o}, {24'd0, m_cfg});
    do_read("status_tie_conversion_wins", 3'd0);
    do_read("temp_after_midread", 3'd2);

    // Continuous mode 00 with preset 10 tracks Temperature_i.
    ConvCyclesPreset_i = 16'd10;
    busy_q.push_back(0);
    do_write(3'd1, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      Temperature_i = 16'($urandom);
      repeat (20) @(negedge Clk_i);
      m_temp = Temperature_i;
      do_read("temp_mode00_track", 3'd2);
      check("busy_mode00_running", {31'd0, Busy_o}, 32'd1);
    end
    do_write(3'd1, 16'h0060);
    m_rdy_n = 1'b0;
    check("busy_after_stop", {31'd0, Busy_o}, 32'd0);
    do_read("status_after_mode00", 3'd0);
    do_read("temp_after_mode00", 3'd2);

    for (int i = 0; i < 2000 && (rd_q.size() > 0 || busy_q.size() > 0); i++) @(negedge Clk_i);
    check("rd_queue_drained", rd_q.size(), 0);
    check("busy_queue_drained", busy_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
